// File: rtl/mux_nch_scan.sv
// N-channel WIDTH-bit registered multiplexer with MANUAL (latched select) and AUTO (round-robin scan) modes.
// Optional macro MUX_DWELL_EN: in AUTO, hold each channel DWELL cycles before advancing.
module mux_nch_scan #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(N_CH),
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic [N_CH-1:0]       in_valid,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  output logic [WIDTH-1:0]      z,
  output logic                  z_valid,
  output logic [SEL_W-1:0]      cur_ch,
  output logic                  sel_err
);

  typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

  if ((N_CH < 2) || (DWELL < 1)) begin : g_param_check
    $error("mux_nch_scan: N_CH must be >= 2 and DWELL >= 1");
  end

  logic [WIDTH-1:0] ch [N_CH];
  state_t           state_s;
  logic [SEL_W-1:0] sel_r, sel_s, next_ch_s;
  logic [SEL_W:0]   cand_s;
  logic             found_s, advance_s;
  logic [WIDTH-1:0] z_s;
  logic             z_valid_s, sel_err_s;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch[k] = din[k*WIDTH +: WIDTH];
  end

  assign cur_ch = sel_r;

`ifdef MUX_DWELL_EN
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  // state register: remembers the previous mode so AUTO entry can be detected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_MANUAL;
    end else begin
      state_r <= state_s;
    end
  end

  // dwell counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_s;
    end
  end

  // dwell decision: stay while the held channel is valid and the dwell time has not run out
  always_comb begin
    if ((state_s == ST_AUTO) && (state_r == ST_AUTO) &&
        (cnt_r != DWELL_LAST) && in_valid[sel_r]) begin
      advance_s = 1'b0;
      cnt_s     = cnt_r + CNT_W'(1);
    end else begin
      advance_s = 1'b1;
      cnt_s     = '0;
    end
  end
`else
  assign advance_s = 1'b1;
`endif

  // next-state logic: state simply follows the mode input
  always_comb begin
    case (mode)
      1'b0:    state_s = ST_MANUAL;
      1'b1:    state_s = ST_AUTO;
      default: state_s = ST_MANUAL;
    endcase
  end

  // round-robin search; descending loop so the nearest valid channel after sel_r wins
  always_comb begin
    found_s   = 1'b0;
    next_ch_s = sel_r;
    cand_s    = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand_s    = {1'b0, sel_r} + (SEL_W + 1)'(k);
      cand_s    = (cand_s >= N_CH_W) ? (cand_s - N_CH_W) : cand_s;
      next_ch_s = in_valid[cand_s[SEL_W-1:0]] ? cand_s[SEL_W-1:0] : next_ch_s;
      found_s   = found_s | in_valid[cand_s[SEL_W-1:0]];
    end
  end

  // output/next-datapath logic for both modes
  always_comb begin
    sel_s     = sel_r;
    z_s       = ch[sel_r];
    z_valid_s = in_valid[sel_r];
    sel_err_s = 1'b0;
    case (state_s)
      ST_MANUAL: begin
        if (load) begin
          if ({1'b0, sel} < N_CH_W) begin
            sel_s = sel;
          end else begin
            sel_err_s = 1'b1;
          end
        end else begin
          sel_s = sel_r;
        end
      end
      ST_AUTO: begin
        if (!advance_s) begin
          sel_s = sel_r;
        end else if (found_s) begin
          sel_s     = next_ch_s;
          z_s       = ch[next_ch_s];
          z_valid_s = 1'b1;
        end else begin
          z_s       = z;
          z_valid_s = 1'b0;
        end
      end
      default: begin
        sel_s = sel_r;
      end
    endcase
  end

  // output and select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r   <= '0;
      z       <= '0;
      z_valid <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      sel_r   <= sel_s;
      z       <= z_s;
      z_valid <= z_valid_s;
      sel_err <= sel_err_s;
    end
  end

endmodule

// File: tb/tb_mux_nch_scan.sv
// Scoreboard bench for mux_nch_scan: a 4-channel instance for select/scan/mode tests
// and a 3-channel instance for the illegal-select case.
module tb_mux_nch_scan;

  typedef struct {
    string      name;
    bit         which;
    logic [7:0] z;
    logic       zv;
    logic [1:0] cur;
    logic       err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [3:0]  in_valid;
  logic        mode, load;
  logic [1:0]  sel;
  logic [7:0]  z;
  logic        z_valid, sel_err;
  logic [1:0]  cur_ch;

  logic [23:0] din3;
  logic [2:0]  in_valid3;
  logic        mode3, load3;
  logic [1:0]  sel3;
  logic [7:0]  z3;
  logic        z_valid3, sel_err3;
  logic [1:0]  cur_ch3;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_nch_scan #(.N_CH(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .mode(mode),
    .sel(sel), .load(load), .z(z), .z_valid(z_valid), .cur_ch(cur_ch), .sel_err(sel_err)
  );

  mux_nch_scan #(.N_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din3), .in_valid(in_valid3), .mode(mode3),
    .sel(sel3), .load(load3), .z(z3), .z_valid(z_valid3), .cur_ch(cur_ch3), .sel_err(sel_err3)
  );

  task automatic compare(input string nm, input logic [7:0] az, input logic azv,
                         input logic [1:0] acur, input logic aerr, input exp_t e);
    checks++;
    if (az !== e.z || azv !== e.zv || acur !== e.cur || aerr !== e.err) begin
      failures++;
      $display("FAIL %s: got z=%h z_valid=%b cur_ch=%0d sel_err=%b, need z=%h z_valid=%b cur_ch=%0d sel_err=%b",
               nm, az, azv, acur, aerr, e.z, e.zv, e.cur, e.err);
    end
  endtask

  // monitor: one expectation per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.which) compare(e.name, z3, z_valid3, cur_ch3, sel_err3, e);
        else         compare(e.name, z, z_valid, cur_ch, sel_err, e);
      end
    end
  end

  task automatic step(input logic m, input logic ld, input logic [1:0] s, input logic [3:0] v,
                      input string nm, input logic [7:0] ez, input logic ezv, input logic [1:0] ecur);
    mode = m; load = ld; sel = s; in_valid = v;
    sb.push_back('{nm, 1'b0, ez, ezv, ecur, 1'b0});
    @(posedge clk);
    #2;
  endtask

  task automatic step3(input logic ld, input logic [1:0] s, input string nm,
                       input logic [7:0] ez, input logic [1:0] ecur, input logic eerr);
    load3 = ld; sel3 = s;
    sb.push_back('{nm, 1'b1, ez, 1'b1, ecur, eerr});
    @(posedge clk);
    #2;
  endtask

  task automatic check_now(input string nm);
    exp_t e;
    e = '{nm, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
    compare(nm, z, z_valid, cur_ch, sel_err, e);
  endtask

  initial begin
    rst_n = 1'b0;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid = 4'b1111; mode = 1'b1; load = 1'b1; sel = 2'd3;
    din3 = {8'hC3, 8'hB2, 8'hA1};
    in_valid3 = 3'b111; mode3 = 1'b0; load3 = 1'b0; sel3 = 2'd0;
    repeat (3) @(posedge clk);
    #2;
    check_now("reset_held");
    mode = 1'b0; load = 1'b0; sel = 2'd0;
    rst_n = 1'b1;
    #1;
    check_now("reset_release");

    // MANUAL: load takes one edge, data follows one edge later
    step(1'b0, 1'b1, 2'd2, 4'b1111, "man_load2",  8'h11, 1'b1, 2'd2);
    step(1'b0, 1'b0, 2'd0, 4'b1111, "man_z2",     8'h33, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd0, 4'b1111, "man_load0",  8'h33, 1'b1, 2'd0);
    step(1'b0, 1'b0, 2'd0, 4'b1111, "man_z0",     8'h11, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd1, 4'b1111, "man_load1",  8'h11, 1'b1, 2'd1);
    step(1'b0, 1'b0, 2'd0, 4'b1111, "man_z1",     8'h22, 1'b1, 2'd1);
    step(1'b0, 1'b1, 2'd3, 4'b1111, "man_load3",  8'h22, 1'b1, 2'd3);
    step(1'b0, 1'b0, 2'd0, 4'b1111, "man_z3",     8'h44, 1'b1, 2'd3);
    step(1'b0, 1'b0, 2'd0, 4'b0111, "man_invalid", 8'h44, 1'b0, 2'd3);
    step(1'b0, 1'b1, 2'd0, 4'b1111, "man_back0",  8'h44, 1'b1, 2'd0);

    // AUTO scan over 4'b1011 from channel 0
    step(1'b1, 1'b0, 2'd0, 4'b1011, "auto_1",     8'h22, 1'b1, 2'd1);
    step(1'b1, 1'b0, 2'd0, 4'b1011, "auto_3",     8'h44, 1'b1, 2'd3);
    step(1'b1, 1'b0, 2'd0, 4'b1011, "auto_wrap0", 8'h11, 1'b1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 4'b1011, "auto_1b",    8'h22, 1'b1, 2'd1);
    step(1'b1, 1'b0, 2'd0, 4'b1011, "auto_3b",    8'h44, 1'b1, 2'd3);
    step(1'b1, 1'b0, 2'd0, 4'b0000, "auto_none",  8'h44, 1'b0, 2'd3);
    step(1'b1, 1'b0, 2'd0, 4'b0100, "auto_single", 8'h33, 1'b1, 2'd2);
    step(1'b1, 1'b0, 2'd0, 4'b0100, "auto_single2", 8'h33, 1'b1, 2'd2);
    step(1'b1, 1'b0, 2'd0, 4'b1000, "auto_to3",   8'h44, 1'b1, 2'd3);

    // mode switches
    step(1'b0, 1'b0, 2'd0, 4'b1111, "a2m_hold",   8'h44, 1'b1, 2'd3);
    step(1'b0, 1'b0, 2'd0, 4'b1111, "a2m_stay",   8'h44, 1'b1, 2'd3);
    step(1'b1, 1'b1, 2'd2, 4'b1111, "m2a_noload", 8'h11, 1'b1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 4'b1111, "m2a_next",   8'h22, 1'b1, 2'd1);

    // asynchronous reset between edges
    #1;
    rst_n = 1'b0;
    #1;
    check_now("async_reset");
    @(posedge clk);
    #2;
    mode = 1'b0; load = 1'b0;
    rst_n = 1'b1;

    // 3-channel instance: illegal select
    step3(1'b1, 2'd1, "n3_load1",   8'hA1, 2'd1, 1'b0);
    step3(1'b0, 2'd0, "n3_z1",      8'hB2, 2'd1, 1'b0);
    step3(1'b1, 2'd3, "n3_illegal", 8'hB2, 2'd1, 1'b1);
    step3(1'b0, 2'd0, "n3_err_end", 8'hB2, 2'd1, 1'b0);
    step3(1'b1, 2'd2, "n3_load2",   8'hB2, 2'd2, 1'b0);
    step3(1'b0, 2'd0, "n3_z2",      8'hC3, 2'd2, 1'b0);

    @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending entries, need 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
